// File: rtl/svo_stream_switch.sv
// Frame-aligned 2:1 switch for SVO AXI video streams. A source change takes effect only at a
// frame boundary. The source that is not forwarding is drained so that it never stalls.
module svo_stream_switch #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned HOR_PIXELS = 640,
  parameter int unsigned VER_PIXELS = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              in0_axis_tvalid,
  output logic              in0_axis_tready,
  input  logic [DATA_W-1:0] in0_axis_tdata,
  input  logic              in0_axis_tuser,
  input  logic              in1_axis_tvalid,
  output logic              in1_axis_tready,
  input  logic [DATA_W-1:0] in1_axis_tdata,
  input  logic              in1_axis_tuser,
  output logic              out_axis_tvalid,
  input  logic              out_axis_tready,
  output logic [DATA_W-1:0] out_axis_tdata,
  output logic              out_axis_tuser,
  output logic              active_src,
  output logic              switching
);

  localparam int unsigned FRAME_PIXELS = HOR_PIXELS * VER_PIXELS;
  localparam int unsigned CNT_W        = $clog2(FRAME_PIXELS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_PIXELS);

  typedef enum logic [1:0] {SYNC = 2'd0, PASS = 2'd1, DRAIN = 2'd2} state_t;

  state_t            state, state_nx;
  logic              active_nx;
  logic [CNT_W-1:0]  pix_cnt, cnt_nx;
  logic              src, cap, cur_valid, cur_user, cur_ready, fwd;
  logic [DATA_W-1:0] cur_data;

  // While hunting for a SOF the requested source is followed directly.
  assign src       = (state == SYNC) ? sel : active_src;
  assign cur_valid = src ? in1_axis_tvalid : in0_axis_tvalid;
  assign cur_user  = src ? in1_axis_tuser  : in0_axis_tuser;
  assign cur_data  = src ? in1_axis_tdata  : in0_axis_tdata;
  assign cap       = !out_axis_tvalid || out_axis_tready;

  assign in0_axis_tready = src ? 1'b1 : cur_ready;
  assign in1_axis_tready = src ? cur_ready : 1'b1;

  // Per-state acceptance and pixel counting.
  always_comb begin
    cur_ready = 1'b0;
    fwd       = 1'b0;
    cnt_nx    = pix_cnt;
    case (state)
      SYNC: begin
        cur_ready = !cur_user || cap;
        fwd       = cur_valid && cur_user && cap;
      end
      PASS: begin
        cur_ready = cap;
        fwd       = cur_valid && cap;
      end
      DRAIN: begin
        cur_ready = cap && !cur_user;
        fwd       = cur_valid && cap && !cur_user;
      end
      default: cur_ready = 1'b0;
    endcase
    if (fwd) begin
      if (cur_user) cnt_nx = CNT_W'(1);
      else if (pix_cnt != CNT_MAX) cnt_nx = pix_cnt + CNT_W'(1);
    end
  end

  // Next state; a returning sel in DRAIN outranks the end-of-frame exit.
  always_comb begin
    state_nx  = state;
    active_nx = active_src;
    case (state)
      SYNC: begin
        active_nx = sel;
        if (fwd) state_nx = PASS;
      end
      PASS: begin
        if (sel != active_src) state_nx = DRAIN;
      end
      DRAIN: begin
        if (sel == active_src) begin
          state_nx = PASS;
        end else if ((cur_valid && cur_user) || (fwd && cnt_nx == CNT_MAX)) begin
          state_nx  = SYNC;
          active_nx = sel;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SYNC;
      active_src <= 1'b0;
      pix_cnt    <= '0;
      switching  <= 1'b1;
    end else begin
      state      <= state_nx;
      active_src <= active_nx;
      pix_cnt    <= cnt_nx;
      switching  <= (state_nx != PASS);
    end
  end

  // One-deep output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_axis_tvalid <= 1'b0;
      out_axis_tdata  <= '0;
      out_axis_tuser  <= 1'b0;
    end else if (fwd) begin
      out_axis_tvalid <= 1'b1;
      out_axis_tdata  <= cur_data;
      out_axis_tuser  <= cur_user;
    end else if (out_axis_tready) begin
      out_axis_tvalid <= 1'b0;
    end
  end

endmodule
